fwd_select_stage: RTL

- Parametrised, registered successor to the 3-way forwarding mux used in the pipelined datapath.
- Selects one of NUM_SRC operand sources with a binary selector.
- Registers the result behind a valid/ready handshake with a one-entry skid buffer, so `in_ready` is registered.
- Sits between the hazard/forwarding logic and the EX-stage ALU operand input; supports pipeline flush.

---
 rtl/fwd_pkg.sv | 20 ++
 rtl/fwd_sel_mux.sv | 27 ++
 rtl/fwd_select_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding select stage and the hazard unit.
package fwd_pkg;

  // Default geometry shared with the hazard/forwarding unit.
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_SRC = 3;

  // Occupancy of the output/skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fwd_state_t;

  // Selector width for n sources; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fwd_sel_mux.sv
// Combinational N-way operand selector; an out-of-range index yields zero data and err=1.
module fwd_sel_mux
  import fwd_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int SEL_W   = sel_width(NUM_SRC)
) (
  input  logic [NUM_SRC*WIDTH-1:0] src,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         data,
  output logic                     err
);

  // Fully decoded select: defaults cover every index with no matching source.
  always_comb begin
    data = '0;
    err  = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (32'(sel) == 32'(k)) begin
        data = src[k*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fwd_select_stage.sv
// Registered forwarding mux: selects one operand source and holds it behind a
// valid/ready handshake with a one-entry skid buffer so in_ready comes from a flop.
module fwd_select_stage
  import fwd_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int SEL_W   = sel_width(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_sel_err,
  output logic                     out_valid,
  input  logic                     out_ready
);

  fwd_state_t       state, state_nxt;
  logic [WIDTH-1:0] sel_data_p0;
  logic             sel_err_p0;
  logic [WIDTH-1:0] out_data_p1, skid_data_p1;
  logic             out_err_p1, skid_err_p1;
  logic             out_valid_p1, in_ready_p1;
  logic             accept, xfer;
  logic             load_new, load_skid, move_skid;

  fwd_sel_mux #(
    .WIDTH  (WIDTH),
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W)
  ) u_mux (
    .src (in_data),
    .sel (in_sel),
    .data(sel_data_p0),
    .err (sel_err_p0)
  );

  assign accept = in_valid & in_ready_p1;
  assign xfer   = out_valid_p1 & out_ready;

  // Next occupancy and register enables; flush empties the stage and suppresses all loads.
  always_comb begin
    state_nxt = state;
    load_new  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          load_new  = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          load_new = 1'b1;
        end else if (accept) begin
          state_nxt = ST_TWO;
          load_skid = 1'b1;
        end else if (xfer) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (xfer) begin
          state_nxt = ST_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      state_nxt = ST_EMPTY;
      load_new  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  // Control flops; handshake outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_EMPTY;
      out_valid_p1 <= 1'b0;
      in_ready_p1  <= 1'b1;
    end else begin
      state        <= state_nxt;
      out_valid_p1 <= (state_nxt != ST_EMPTY);
      in_ready_p1  <= (state_nxt != ST_TWO);
    end
  end

  // ---- stage p0 -> p1: output register, fed by a fresh beat or the skid entry ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_p1 <= '0;
      out_err_p1  <= 1'b0;
    end else if (load_new) begin
      out_data_p1 <= sel_data_p0;
      out_err_p1  <= sel_err_p0;
    end else if (move_skid) begin
      out_data_p1 <= skid_data_p1;
      out_err_p1  <= skid_err_p1;
    end
  end

  // Skid register captures a beat accepted while the output is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_data_p1 <= '0;
      skid_err_p1  <= 1'b0;
    end else if (load_skid) begin
      skid_data_p1 <= sel_data_p0;
      skid_err_p1  <= sel_err_p0;
    end
  end

  assign out_data    = out_data_p1;
  assign out_sel_err = out_err_p1;
  assign out_valid   = out_valid_p1;
  assign in_ready    = in_ready_p1;

endmodule
